// File: rtl/axi_lite_aes_regs_pkg.sv
// axi_lite_aes_pkg: shared response codes, register offsets, FSM states and address decode
package axi_lite_aes_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [7:0] OFF_KEY    = 8'h00;
  localparam logic [7:0] OFF_BLOCK  = 8'h10;
  localparam logic [7:0] OFF_IV     = 8'h20;
  localparam logic [7:0] OFF_RESULT = 8'h30;
  localparam logic [7:0] OFF_CTRL   = 8'h40;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  typedef enum logic [2:0] {REG_KEY, REG_BLOCK, REG_IV, REG_RESULT, REG_CTRL, REG_NONE} region_t;
  typedef struct packed {
    region_t    region;
    logic [1:0] resp;
  } dec_t;
  // Window/offset errors outrank protection errors; RESULT is never bus-writable.
  function automatic dec_t decode(input logic [31:0] addr, input logic [2:0] prot,
                                  input logic is_write, input logic [23:0] base);
    dec_t d;
    d.region = (addr[7:4] == OFF_KEY[7:4])    ? REG_KEY :
               (addr[7:4] == OFF_BLOCK[7:4])  ? REG_BLOCK :
               (addr[7:4] == OFF_IV[7:4])     ? REG_IV :
               (addr[7:4] == OFF_RESULT[7:4]) ? REG_RESULT :
               (addr[7:2] == OFF_CTRL[7:2])   ? REG_CTRL : REG_NONE;
    d.resp = (addr[31:8] != base || d.region == REG_NONE) ? RESP_DECERR :
             (prot[1:0] != 2'b11 || (is_write && d.region == REG_RESULT)) ? RESP_SLVERR :
             RESP_OKAY;
    return d;
  endfunction
endpackage

// File: rtl/axi_lite_aes_regs_if.sv
// axi_lite_aes_regs_if: AXI4-Lite bus bundle with master/slave views
interface axi_lite_aes_regs_if;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_aes_regs_bank.sv
// aes_reg_bank: AES operand/result storage with byte-strobe writes and word read mux
module aes_reg_bank
  import axi_lite_aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  region_t      w_region,
  input  logic [1:0]   w_word,
  input  logic [31:0]  wdata,
  input  logic [3:0]   wstrb,
  input  region_t      r_region,
  input  logic [1:0]   r_word,
  input  logic         res_wr,
  input  logic [127:0] res_data,
  output logic [127:0] key,
  output logic [127:0] block,
  output logic [127:0] iv,
  output logic [31:0]  ctrl,
  output logic [31:0]  rdata
);
  logic [127:0] result;
  logic [6:0]   wsel, rsel;
  assign wsel = {w_word, 5'd0};
  assign rsel = {r_word, 5'd0};
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] strb);
    for (int i = 0; i < 4; i++) if (strb[i]) old[i*8 +: 8] = d[i*8 +: 8];
    return old;
  endfunction
  // Bus writes land one word at a time; the core result load is independent of the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key    <= '0;
      block  <= '0;
      iv     <= '0;
      ctrl   <= '0;
      result <= '0;
    end else begin
      if (we && w_region == REG_KEY)   key[wsel +: 32]   <= merge(key[wsel +: 32], wdata, wstrb);
      if (we && w_region == REG_BLOCK) block[wsel +: 32] <= merge(block[wsel +: 32], wdata, wstrb);
      if (we && w_region == REG_IV)    iv[wsel +: 32]    <= merge(iv[wsel +: 32], wdata, wstrb);
      if (we && w_region == REG_CTRL)  ctrl              <= merge(ctrl, wdata, wstrb);
      if (res_wr) result <= res_data;
    end
  end
  // Word read mux; unmapped regions read as zero.
  always_comb begin
    rdata = (r_region == REG_KEY)    ? key[rsel +: 32] :
            (r_region == REG_BLOCK)  ? block[rsel +: 32] :
            (r_region == REG_IV)     ? iv[rsel +: 32] :
            (r_region == REG_RESULT) ? result[rsel +: 32] :
            (r_region == REG_CTRL)   ? ctrl : 32'd0;
  end
endmodule

// File: rtl/axi_lite_aes_regs.sv
// axi_lite_aes_regs: AXI4-Lite slave exposing AES key/block/iv/ctrl/result registers
module axi_lite_aes_regs
  import axi_lite_aes_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'h000000
) (
  input  logic                 ACLK,
  input  logic                 ARST,
  axi_lite_aes_regs_if.slave   bus,
  output logic [127:0]         key,
  output logic [127:0]         block,
  output logic [127:0]         iv,
  output logic [31:0]          ctrl,
  input  logic                 res_wr,
  input  logic [127:0]         res_data
);
  logic [1:0]  w_state;
  logic [0:0]  r_state;
  logic [31:0] aw_addr;
  logic [2:0]  aw_prot;
  logic [31:0] bank_rdata;
  logic        we;
  dec_t        wdec, rdec;
  assign wdec = decode(aw_addr, aw_prot, 1'b1, BASE_ADDR);
  assign rdec = decode(bus.araddr, bus.arprot, 1'b0, BASE_ADDR);
  assign we   = (w_state == W_DATA) && bus.wvalid && (wdec.resp == RESP_OKAY);
  aes_reg_bank u_bank (
    .clk      (ACLK),
    .rst      (ARST),
    .we       (we),
    .w_region (wdec.region),
    .w_word   (aw_addr[3:2]),
    .wdata    (bus.wdata),
    .wstrb    (bus.wstrb),
    .r_region (rdec.region),
    .r_word   (bus.araddr[3:2]),
    .res_wr   (res_wr),
    .res_data (res_data),
    .key      (key),
    .block    (block),
    .iv       (iv),
    .ctrl     (ctrl),
    .rdata    (bank_rdata)
  );
  // Write channel: address first, then data (committed when sampled), then response.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      w_state     <= W_IDLE;
      aw_addr     <= '0;
      aw_prot     <= '0;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: if (bus.awvalid) begin
          aw_addr     <= bus.awaddr;
          aw_prot     <= bus.awprot;
          bus.awready <= 1'b1;
          w_state     <= W_DATA;
        end
        W_DATA: begin
          bus.awready <= 1'b0;
          if (bus.wvalid) begin
            bus.wready <= 1'b1;
            bus.bresp  <= wdec.resp;
            w_state    <= W_RESP;
          end
        end
        default: begin
          bus.wready <= 1'b0;
          if (!bus.bvalid) bus.bvalid <= 1'b1;
          else if (bus.bready) begin
            bus.bvalid <= 1'b0;
            w_state    <= W_IDLE;
          end
        end
      endcase
    end
  end
  // Read channel: data is captured with the address, so it reflects pre-write contents.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      r_state     <= R_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= RESP_OKAY;
    end else if (r_state == R_IDLE) begin
      if (bus.arvalid) begin
        bus.arready <= 1'b1;
        bus.rdata   <= (rdec.resp == RESP_OKAY) ? bank_rdata : 32'd0;
        bus.rresp   <= rdec.resp;
        r_state     <= R_DATA;
      end
    end else begin
      bus.arready <= 1'b0;
      if (!bus.rvalid) bus.rvalid <= 1'b1;
      else if (bus.rready) begin
        bus.rvalid <= 1'b0;
        r_state    <= R_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_aes_regs.sv
// tb_axi_lite_aes_regs: scoreboard bench for the AES AXI4-Lite register block
module tb_axi_lite_aes_regs;
  import axi_lite_aes_pkg::*;
  logic         ACLK = 1'b0;
  logic         ARST = 1'b1;
  logic         res_wr = 1'b0;
  logic [127:0] res_data = '0;
  logic [127:0] key, block, iv;
  logic [31:0]  ctrl;
  int           checks = 0;
  int           errors = 0;
  logic [127:0] m_key = '0, m_block = '0, m_iv = '0, m_res = '0;
  logic [31:0]  m_ctrl = '0;
  logic [1:0]   bq[$];
  logic [33:0]  rq[$];
  axi_lite_aes_regs_if bus();
  axi_lite_aes_regs #(.BASE_ADDR(24'h000000)) dut (
    .ACLK     (ACLK),
    .ARST     (ARST),
    .bus      (bus),
    .key      (key),
    .block    (block),
    .iv       (iv),
    .ctrl     (ctrl),
    .res_wr   (res_wr),
    .res_data (res_data)
  );
  always #5 ACLK = ~ACLK;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] strb);
    for (int i = 0; i < 4; i++) if (strb[i]) old[i*8 +: 8] = d[i*8 +: 8];
    return old;
  endfunction
  function automatic logic [31:0] mword(input logic [31:0] a);
    logic [6:0] s;
    s = {a[3:2], 5'd0};
    case (a[7:4])
      4'h0: return m_key[s +: 32];
      4'h1: return m_block[s +: 32];
      4'h2: return m_iv[s +: 32];
      4'h3: return m_res[s +: 32];
      4'h4: return m_ctrl;
      default: return 32'd0;
    endcase
  endfunction
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
    logic [6:0] s;
    s = {a[3:2], 5'd0};
    case (a[7:4])
      4'h0: m_key[s +: 32]   = merge(m_key[s +: 32], d, strb);
      4'h1: m_block[s +: 32] = merge(m_block[s +: 32], d, strb);
      4'h2: m_iv[s +: 32]    = merge(m_iv[s +: 32], d, strb);
      4'h4: m_ctrl           = merge(m_ctrl, d, strb);
      default: ;
    endcase
  endtask
  function automatic logic [42:0] hs_outs();
    return {bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready, bus.rvalid,
            bus.rresp, bus.rdata};
  endfunction
  task automatic bus_write(input logic [31:0] a, input logic [2:0] p, input logic [31:0] d,
                           input logic [3:0] strb, input logic [1:0] exp, input bit hold = 0);
    int n;
    logic [1:0] got;
    bq.push_back(exp);
    if (exp == RESP_OKAY) model_write(a, d, strb);
    @(posedge ACLK); #1;
    bus.awvalid = 1'b1; bus.awaddr = a; bus.awprot = p;
    for (n = 0; n < 50 && !bus.awready; n++) @(negedge ACLK);
    chk("awready_seen", n < 50, 1'b1);
    @(posedge ACLK); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = strb;
    for (n = 0; n < 50 && !bus.wready; n++) @(negedge ACLK);
    chk("wready_seen", n < 50, 1'b1);
    @(posedge ACLK); #1;
    bus.wvalid = 1'b0; bus.bready = !hold;
    for (n = 0; n < 50 && !bus.bvalid; n++) @(negedge ACLK);
    got = bus.bresp;
    chk("bresp", {n < 50, got}, {1'b1, bq.pop_front()});
    if (hold) begin
      repeat (5) begin
        @(negedge ACLK);
        chk("bvalid_hold", {bus.bvalid, bus.bresp}, {1'b1, got});
      end
      bus.bready = 1'b1;
    end
    @(posedge ACLK); #1;
    bus.bready = 1'b0;
    chk("bvalid_drop", bus.bvalid, 1'b0);
  endtask
  task automatic bus_read(input logic [31:0] a, input logic [2:0] p, input logic [1:0] exp,
                          input bit hold = 0);
    int n;
    logic [33:0] got;
    rq.push_back({exp, (exp == RESP_OKAY) ? mword(a) : 32'd0});
    @(posedge ACLK); #1;
    bus.arvalid = 1'b1; bus.araddr = a; bus.arprot = p;
    for (n = 0; n < 50 && !bus.arready; n++) @(negedge ACLK);
    chk("arready_seen", n < 50, 1'b1);
    @(posedge ACLK); #1;
    bus.arvalid = 1'b0; bus.rready = !hold;
    for (n = 0; n < 50 && !bus.rvalid; n++) @(negedge ACLK);
    got = {bus.rresp, bus.rdata};
    chk($sformatf("rd_%h", a), {n < 50, got}, {1'b1, rq.pop_front()});
    if (hold) begin
      repeat (5) begin
        @(negedge ACLK);
        chk("rvalid_hold", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, got});
      end
      bus.rready = 1'b1;
    end
    @(posedge ACLK); #1;
    bus.rready = 1'b0;
    chk("rvalid_drop", bus.rvalid, 1'b0);
  endtask
  initial begin
    int n;
    bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
    bus.wvalid = 0;  bus.wdata = 0;  bus.wstrb = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0; bus.rready = 0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK); ARST = 1'b0;
    chk("rst_regs", {key, block, iv, ctrl}, '0);
    chk("rst_handshake", hs_outs(), '0);
    for (int i = 0; i < 4; i++) bus_read(32'h20 + 4 * i, 3'b011, RESP_OKAY);
    bus_write(32'h00, 3'b011, 32'h12345ABF, 4'b1101, RESP_OKAY);
    bus_write(32'h04, 3'b011, 32'h4567A9AB, 4'b1111, RESP_OKAY);
    bus_write(32'h08, 3'b011, 32'h12BCDF78, 4'b1111, RESP_OKAY);
    bus_write(32'h0C, 3'b011, 32'h5BFA8398, 4'b1111, RESP_OKAY);
    chk("key_out", key, 128'h5BFA8398_12BCDF78_4567A9AB_123400BF);
    for (int i = 0; i < 4; i++) bus_read(32'h00 + 4 * i, 3'b011, RESP_OKAY);
    bus_read(32'h09, 3'b111, RESP_OKAY);
    bus_read(32'h00, 3'b001, RESP_SLVERR);
    bus_write(32'h20, 3'b001, 32'hDEADBEEF, 4'b1111, RESP_SLVERR);
    chk("iv_unchanged", iv, m_iv);
    bus_write(32'h30, 3'b011, 32'h12345ABF, 4'b1111, RESP_SLVERR);
    bus_read(32'h30, 3'b011, RESP_OKAY);
    @(posedge ACLK); #1;
    res_wr = 1'b1; res_data = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    m_res = res_data;
    @(posedge ACLK); #1;
    res_wr = 1'b0;
    for (int i = 0; i < 4; i++) bus_read(32'h30 + 4 * i, 3'b011, RESP_OKAY);
    bus_write(32'h14, 3'b011, 32'hA5A5_0F0F, 4'b0011, RESP_OKAY);
    bus_write(32'h40, 3'b111, 32'h0000_0081, 4'b1111, RESP_OKAY);
    chk("block_out", block, m_block);
    chk("ctrl_out", ctrl, m_ctrl);
    bus_read(32'h14, 3'b011, RESP_OKAY);
    bus_read(32'h40, 3'b011, RESP_OKAY);
    bus_read(32'h50, 3'b011, RESP_DECERR);
    bus_read(32'h44, 3'b011, RESP_DECERR);
    bus_read(32'h0100_0000, 3'b011, RESP_DECERR);
    bus_write(32'h50, 3'b011, 32'hFFFF_FFFF, 4'b1111, RESP_DECERR);
    bus_write(32'h0100_0004, 3'b001, 32'hFFFF_FFFF, 4'b1111, RESP_DECERR);
    chk("key_after_decerr", key, m_key);
    bus_read(32'h04, 3'b011, RESP_OKAY, 1);
    bus_write(32'h28, 3'b011, 32'h600D_F00D, 4'b1111, RESP_OKAY, 1);
    chk("iv_out", iv, m_iv);
    @(posedge ACLK); #1;
    bus.awvalid = 1'b1; bus.awaddr = 32'h00; bus.awprot = 3'b011;
    for (n = 0; n < 50 && !bus.awready; n++) @(negedge ACLK);
    chk("rst_awready_seen", n < 50, 1'b1);
    @(posedge ACLK); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b1; bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF;
    ARST = 1'b1;
    m_key = '0; m_block = '0; m_iv = '0; m_res = '0; m_ctrl = '0;
    #1;
    chk("midrst_handshake", hs_outs(), '0);
    chk("midrst_regs", {key, block, iv, ctrl}, '0);
    @(negedge ACLK); ARST = 1'b0;
    repeat (4) begin
      @(negedge ACLK);
      chk("no_w_before_aw", {bus.wready, bus.bvalid}, 2'b00);
    end
    bus.wvalid = 1'b0;
    chk("midrst_key", key, m_key);
    bus_read(32'h00, 3'b011, RESP_OKAY);
    bus_read(32'h30, 3'b011, RESP_OKAY);
    bus_write(32'h0C, 3'b011, 32'hCAFE_BABE, 4'b1010, RESP_OKAY);
    bus_read(32'h0C, 3'b011, RESP_OKAY);
    chk("key_final", key, m_key);
    chk("queues_empty", {bq.size() == 0, rq.size() == 0}, 2'b11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
